fpga_top: RTL and testbench
===========================

FPGA_TOP -- requirements
Module: fpga_top

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, instruction queue depth in entries (power of 2, 2..16).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 core_clk  in  1  sole clock; all logic on rising edge.
REQ-004 sys_rst  in  1  synchronous active-high reset.
REQ-005 ins_valid  in  1  instruction offered.
REQ-006 ins_ready  out  1  instruction can be accepted.
REQ-007 ins  in  64  instruction word.
REQ-008 working  out  1  queue non-empty or executor busy.
REQ-009 cN_init_calib_complete  in  1  DDR channel N (N=0,1) calibrated.
REQ-010 cN_data_compare_error  in  1  DDR channel N self-test error.
REQ-011 cN_sys_clk_p / cN_sys_clk_n  out  1 each  DDR reference clock, p=core_clk, n=~core_clk.
REQ-012 cN_ddr4_act_n, _cke[0:0], _odt[0:0], _cs_n[0:0], _ck_t, _ck_c, _reset_n  out  1 each  DDR control pins.
REQ-013 cN_ddr4_adr[16:0], _ba[1:0], _bg[0:0]  out  DDR address/bank pins.
REQ-014 cN_ddr4_dm_dbi_n[7:0], _dq[63:0], _dqs_t[7:0], _dqs_c[7:0]  inout  DDR data pins.

Function
REQ-015 Opcode ins[63:60]: 0=CONF, 1=LOAD, 2=CALC, 3=SAVE; other values = NOP.
REQ-016 LOAD/SAVE fields: [59:56] sub-op, [55:52] buffer index, [51:44] buffer address, [43:32] length L, [31:0] DDR address.
REQ-017 CONF stores ins[59:0] into conf_reg; conf_reg[7:0] = calc count C.
REQ-018 calib_ok = c0_init_calib_complete & c1_init_calib_complete.
REQ-019 err_sticky sets when either data_compare_error is high; clears only on reset.
REQ-020 ins_ready = calib_ok & ~err_sticky & ~queue_full; combinational from registered state.
REQ-021 Transfer on rising edge with ins_valid & ins_ready; ins_valid is ignored when ins_ready is low.
REQ-022 Accepted words are enqueued in order; simultaneous enqueue and dequeue when full is not allowed, because ready is low when full.
REQ-023 Executor FSM: IDLE -> EXEC on a non-empty queue, popping the head the same cycle; EXEC -> IDLE when the busy counter reaches 0.
REQ-024 Busy cycles per opcode: CONF=1, NOP=1, LOAD=L+1, SAVE=L+1, CALC=C+1, where C is conf_reg[7:0] at pop time.
REQ-025 CONF updates conf_reg on the pop cycle, so a CALC popped later uses the new C.
REQ-026 err_sticky does not abort the current instruction; queued instructions still drain.
REQ-027 working = ~queue_empty | (state != IDLE); it is registered, so it rises 1 cycle after the first accept.
REQ-028 DDR pins held idle: act_n=1, cs_n=1, cke=0, odt=0, adr/ba/bg=0, ck_t=core_clk, ck_c=~core_clk, reset_n=~sys_rst; dq, dqs and dm are high-Z.

Reset
REQ-029 Reset empties the queue, sets FSM=IDLE, busy counter=0, conf_reg=0, err_sticky=0, working=0; ins_ready=0 while sys_rst is high.
REQ-030 Reset mid-execution abandons the current instruction and all queued instructions immediately.

Structure
REQ-031 Shared package fpga_top_pkg: opcode enum, LOAD/SAVE field offsets, FSM state typedef.
REQ-032 One sub-module ins_fifo (sync FIFO, FIFO_DEPTH entries, 64-bit wide, full/empty flags).

Verification
REQ-033 calib inputs 0, ins_valid=1 -> ins_ready=0, working=0; both calib inputs 1 -> ins_ready=1 next cycle.
REQ-034 CONF with [7:0]=15, then CALC -> CALC busy 16 cycles; working drops after the queue drains.
REQ-035 LOAD with L=180 -> executor busy 181 cycles; a following LOAD with L=198 -> busy 199 cycles, in order.
REQ-036 Back-to-back 5 instructions with FIFO_DEPTH=4 during a long LOAD -> ins_ready=0 when full; no word lost or duplicated.
REQ-037 c1_data_compare_error pulse -> ins_ready=0 permanently, queue drains, working=0; sys_rst clears the flag.
REQ-038 sys_rst asserted mid-LOAD -> next cycle working=0, queue empty, FSM=IDLE.

Source files
------------

// File: rtl/fpga_top_pkg.sv
// -----------------------------------------------------------------------------
// fpga_top_pkg
// Shared definitions for the instruction front end of fpga_top:
//   - INS_W / CONF_W / CALC_CNT_W / BUSY_W : word and field widths
//   - opcode_e  : instruction opcodes (anything else executes as a NOP)
//   - ins_t     : LOAD/SAVE field layout of a 64-bit instruction word
//   - state_e   : executor FSM states
//   - busy_preload() : busy-counter load value (busy cycles minus one)
// -----------------------------------------------------------------------------
package fpga_top_pkg;

  localparam int INS_W      = 64;
  localparam int CONF_W     = 60;
  localparam int CALC_CNT_W = 8;
  localparam int BUSY_W     = 12;

  typedef enum logic [3:0] {
    OP_CONF = 4'd0,
    OP_LOAD = 4'd1,
    OP_CALC = 4'd2,
    OP_SAVE = 4'd3
  } opcode_e;

  // Field layout, MSB first: [63:60] opcode, [59:56] sub-op, [55:52] buffer
  // index, [51:44] buffer address, [43:32] length, [31:0] DDR address.
  typedef struct packed {
    logic [3:0]        opcode;
    logic [3:0]        sub_op;
    logic [3:0]        buf_idx;
    logic [7:0]        buf_addr;
    logic [BUSY_W-1:0] len;
    logic [31:0]       ddr_addr;
  } ins_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // The counter is loaded with (busy cycles - 1) and EXEC ends on the cycle
  // it reads zero, so CONF/NOP load 0, LOAD/SAVE load L, CALC loads C.
  function automatic logic [BUSY_W-1:0] busy_preload(
    input logic [3:0]            opcode,
    input logic [BUSY_W-1:0]     len,
    input logic [CALC_CNT_W-1:0] calc_cnt
  );
    logic [BUSY_W-1:0] v;
    v = '0;
    case (opcode)
      OP_LOAD, OP_SAVE: v = len;
      OP_CALC:          v = BUSY_W'(calc_cnt);
      default:          v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fpga_top_if.sv
// -----------------------------------------------------------------------------
// fpga_top_if
// Instruction valid/ready handshake.
//   ins_valid : producer offers an instruction word
//   ins_ready : consumer can accept it this cycle
//   ins       : 64-bit instruction word
// Modports: master (producer side), slave (fpga_top side).
// -----------------------------------------------------------------------------
interface fpga_top_if;
  import fpga_top_pkg::*;

  logic             ins_valid;
  logic             ins_ready;
  logic [INS_W-1:0] ins;

  modport master (output ins_valid, output ins, input ins_ready);
  modport slave  (input ins_valid, input ins, output ins_ready);

endinterface

// File: rtl/fpga_top_ins_fifo.sv
// -----------------------------------------------------------------------------
// ins_fifo
// Synchronous first-word-fall-through FIFO for instruction words.
//   i_clk   : clock            i_srst  : synchronous active-high reset
//   i_push  : write i_data     i_pop   : drop the head word
//   o_data  : head word (valid while o_empty is low)
//   o_full  : DEPTH words held o_empty : no words held
// Pushes while full and pops while empty are ignored.
// -----------------------------------------------------------------------------
module ins_fifo
  import fpga_top_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_push,
  input  logic [INS_W-1:0] i_data,
  input  logic             i_pop,
  output logic [INS_W-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [INS_W-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // The executor pops in the same cycle it decodes the head, so the head is
  // read asynchronously from this small LUT-based store.
  assign o_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/fpga_top.sv
// -----------------------------------------------------------------------------
// fpga_top
// Instruction queue plus a busy-cycle executor, with both DDR4 channels held
// in an idle, quiet state.
//   core_clk / sys_rst        : sole clock, synchronous active-high reset
//   ins_bus (slave)           : ins_valid / ins_ready / ins handshake
//   working                   : queue non-empty or executor busy (registered)
//   cN_init_calib_complete    : channel N calibrated (both gate acceptance)
//   cN_data_compare_error     : channel N error, latched until reset
//   cN_sys_clk_p/_n           : DDR reference clock (core_clk and inverse)
//   cN_ddr4_*                 : DDR4 pins, driven idle; data pins high-Z
// -----------------------------------------------------------------------------
module fpga_top
  import fpga_top_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        core_clk,
  input  logic        sys_rst,
  fpga_top_if.slave   ins_bus,
  output logic        working,

  input  logic        c0_init_calib_complete,
  input  logic        c0_data_compare_error,
  output logic        c0_sys_clk_p,
  output logic        c0_sys_clk_n,
  output logic        c0_ddr4_act_n,
  output logic [16:0] c0_ddr4_adr,
  output logic [1:0]  c0_ddr4_ba,
  output logic [0:0]  c0_ddr4_bg,
  output logic [0:0]  c0_ddr4_cke,
  output logic [0:0]  c0_ddr4_odt,
  output logic [0:0]  c0_ddr4_cs_n,
  output logic        c0_ddr4_ck_t,
  output logic        c0_ddr4_ck_c,
  output logic        c0_ddr4_reset_n,
  inout  wire  [7:0]  c0_ddr4_dm_dbi_n,
  inout  wire  [63:0] c0_ddr4_dq,
  inout  wire  [7:0]  c0_ddr4_dqs_t,
  inout  wire  [7:0]  c0_ddr4_dqs_c,

  input  logic        c1_init_calib_complete,
  input  logic        c1_data_compare_error,
  output logic        c1_sys_clk_p,
  output logic        c1_sys_clk_n,
  output logic        c1_ddr4_act_n,
  output logic [16:0] c1_ddr4_adr,
  output logic [1:0]  c1_ddr4_ba,
  output logic [0:0]  c1_ddr4_bg,
  output logic [0:0]  c1_ddr4_cke,
  output logic [0:0]  c1_ddr4_odt,
  output logic [0:0]  c1_ddr4_cs_n,
  output logic        c1_ddr4_ck_t,
  output logic        c1_ddr4_ck_c,
  output logic        c1_ddr4_reset_n,
  inout  wire  [7:0]  c1_ddr4_dm_dbi_n,
  inout  wire  [63:0] c1_ddr4_dq,
  inout  wire  [7:0]  c1_ddr4_dqs_t,
  inout  wire  [7:0]  c1_ddr4_dqs_c
);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_e              r_state;
  logic [BUSY_W-1:0]   r_busy_cnt;
  logic [CONF_W-1:0]   r_conf_reg;
  logic                r_calib_ok;
  logic                r_err_sticky;
  logic                r_working;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_e              w_state_next;
  logic [BUSY_W-1:0]   w_busy_next;
  logic                w_pop;
  logic                w_push;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [INS_W-1:0]    w_fifo_rd_data;
  ins_t                w_head;
  logic                w_unused;

  // Calibration status is registered, so acceptance opens one cycle after
  // both channels report complete. Reset forces ready low immediately.
  assign ins_bus.ins_ready = r_calib_ok & ~r_err_sticky & ~w_fifo_full & ~sys_rst;
  assign w_push            = ins_bus.ins_valid & ins_bus.ins_ready;
  assign working           = r_working;
  assign w_head            = ins_t'(w_fifo_rd_data);

  ins_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_ins_fifo (
    .i_clk   (core_clk),
    .i_srst  (sys_rst),
    .i_push  (w_push),
    .i_data  (ins_bus.ins),
    .i_pop   (w_pop),
    .o_data  (w_fifo_rd_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Executor FSM: next state, busy counter and pop strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_busy_next  = r_busy_cnt;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_EXEC;
          // CALC samples the count as it stands before this pop; a CONF at the
          // head only takes effect for later instructions.
          w_busy_next  = busy_preload(w_head.opcode, w_head.len,
                                      r_conf_reg[CALC_CNT_W-1:0]);
        end
      end
      ST_EXEC: begin
        if (r_busy_cnt == '0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_busy_next = r_busy_cnt - BUSY_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_busy_next  = '0;
      end
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (sys_rst) begin
      r_state      <= ST_IDLE;
      r_busy_cnt   <= '0;
      r_conf_reg   <= '0;
      r_calib_ok   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_working    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_busy_cnt <= w_busy_next;
      r_calib_ok <= c0_init_calib_complete & c1_init_calib_complete;
      // The error only blocks new instructions; the queue keeps draining.
      if (c0_data_compare_error | c1_data_compare_error) begin
        r_err_sticky <= 1'b1;
      end
      if (w_pop && (w_head.opcode == OP_CONF)) begin
        r_conf_reg <= w_fifo_rd_data[CONF_W-1:0];
      end
      // Built from pre-edge state, so it trails the first accept by a cycle.
      r_working <= ~w_fifo_empty | (r_state != ST_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // DDR4 channels parked idle
  // ---------------------------------------------------------------------------
  assign c0_sys_clk_p     = core_clk;
  assign c0_sys_clk_n     = ~core_clk;
  assign c0_ddr4_act_n    = 1'b1;
  assign c0_ddr4_adr      = '0;
  assign c0_ddr4_ba       = '0;
  assign c0_ddr4_bg       = '0;
  assign c0_ddr4_cke      = '0;
  assign c0_ddr4_odt      = '0;
  assign c0_ddr4_cs_n     = 1'b1;
  assign c0_ddr4_ck_t     = core_clk;
  assign c0_ddr4_ck_c     = ~core_clk;
  assign c0_ddr4_reset_n  = ~sys_rst;
  assign c0_ddr4_dm_dbi_n = 'z;
  assign c0_ddr4_dq       = 'z;
  assign c0_ddr4_dqs_t    = 'z;
  assign c0_ddr4_dqs_c    = 'z;

  assign c1_sys_clk_p     = core_clk;
  assign c1_sys_clk_n     = ~core_clk;
  assign c1_ddr4_act_n    = 1'b1;
  assign c1_ddr4_adr      = '0;
  assign c1_ddr4_ba       = '0;
  assign c1_ddr4_bg       = '0;
  assign c1_ddr4_cke      = '0;
  assign c1_ddr4_odt      = '0;
  assign c1_ddr4_cs_n     = 1'b1;
  assign c1_ddr4_ck_t     = core_clk;
  assign c1_ddr4_ck_c     = ~core_clk;
  assign c1_ddr4_reset_n  = ~sys_rst;
  assign c1_ddr4_dm_dbi_n = 'z;
  assign c1_ddr4_dq       = 'z;
  assign c1_ddr4_dqs_t    = 'z;
  assign c1_ddr4_dqs_c    = 'z;

  // Fields carried in the word but not consumed by this executor.
  assign w_unused = ^{r_conf_reg[CONF_W-1:CALC_CNT_W], w_head.sub_op,
                      w_head.buf_idx, w_head.buf_addr, w_head.ddr_addr};

endmodule

// File: tb/tb_fpga_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fpga_top
// Scoreboard bench: each accepted instruction pushes {word, busy cycles}; a
// monitor measures every EXEC run and pops/compares when the run ends.
// -----------------------------------------------------------------------------
module tb_fpga_top;
  import fpga_top_pkg::*;

  typedef struct {
    logic [63:0] w;
    int          busy;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   model_c  = 0;
  bit   mon_en   = 1'b0;

  logic core_clk = 1'b0;
  logic sys_rst  = 1'b1;
  logic c0_cal = 1'b0, c1_cal = 1'b0, c0_err = 1'b0, c1_err = 1'b0;
  logic working;

  logic        c0_clk_p, c0_clk_n, c0_act_n, c0_ck_t, c0_ck_c, c0_reset_n;
  logic [16:0] c0_adr;
  logic [1:0]  c0_ba;
  logic [0:0]  c0_bg, c0_cke, c0_odt, c0_cs_n;
  wire  [7:0]  c0_dm_unused, c0_dqs_t_unused, c0_dqs_c_unused;
  wire  [63:0] c0_dq_unused;
  logic        c1_clk_p, c1_clk_n, c1_act_n, c1_ck_t, c1_ck_c, c1_reset_n;
  logic [16:0] c1_adr;
  logic [1:0]  c1_ba;
  logic [0:0]  c1_bg, c1_cke, c1_odt, c1_cs_n;
  wire  [7:0]  c1_dm_unused, c1_dqs_t_unused, c1_dqs_c_unused;
  wire  [63:0] c1_dq_unused;

  fpga_top_if bus();

  fpga_top #(.FIFO_DEPTH(4)) dut (
    .core_clk(core_clk), .sys_rst(sys_rst), .ins_bus(bus.slave), .working(working),
    .c0_init_calib_complete(c0_cal), .c0_data_compare_error(c0_err),
    .c0_sys_clk_p(c0_clk_p), .c0_sys_clk_n(c0_clk_n), .c0_ddr4_act_n(c0_act_n),
    .c0_ddr4_adr(c0_adr), .c0_ddr4_ba(c0_ba), .c0_ddr4_bg(c0_bg), .c0_ddr4_cke(c0_cke),
    .c0_ddr4_odt(c0_odt), .c0_ddr4_cs_n(c0_cs_n), .c0_ddr4_ck_t(c0_ck_t),
    .c0_ddr4_ck_c(c0_ck_c), .c0_ddr4_reset_n(c0_reset_n), .c0_ddr4_dm_dbi_n(c0_dm_unused),
    .c0_ddr4_dq(c0_dq_unused), .c0_ddr4_dqs_t(c0_dqs_t_unused), .c0_ddr4_dqs_c(c0_dqs_c_unused),
    .c1_init_calib_complete(c1_cal), .c1_data_compare_error(c1_err),
    .c1_sys_clk_p(c1_clk_p), .c1_sys_clk_n(c1_clk_n), .c1_ddr4_act_n(c1_act_n),
    .c1_ddr4_adr(c1_adr), .c1_ddr4_ba(c1_ba), .c1_ddr4_bg(c1_bg), .c1_ddr4_cke(c1_cke),
    .c1_ddr4_odt(c1_odt), .c1_ddr4_cs_n(c1_cs_n), .c1_ddr4_ck_t(c1_ck_t),
    .c1_ddr4_ck_c(c1_ck_c), .c1_ddr4_reset_n(c1_reset_n), .c1_ddr4_dm_dbi_n(c1_dm_unused),
    .c1_ddr4_dq(c1_dq_unused), .c1_ddr4_dqs_t(c1_dqs_t_unused), .c1_ddr4_dqs_c(c1_dqs_c_unused)
  );

  always #5 core_clk = ~core_clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  function automatic logic [63:0] mk_ls(input logic [3:0] op, input logic [11:0] len,
                                        input logic [31:0] addr);
    return {op, 4'h1, 4'h2, 8'h5A, len, addr};
  endfunction

  function automatic logic [63:0] mk_conf(input logic [7:0] c);
    return {4'h0, 52'h0123456789ABC, c};
  endfunction

  // Offer one word; it is recorded as accepted only at a negedge where ready
  // is high, because the following posedge then performs the transfer.
  task automatic send(input logic [63:0] w);
    int n;
    int busy;
    n = 0;
    busy = 1;
    @(negedge core_clk);
    bus.ins_valid = 1'b1;
    bus.ins       = w;
    while (!bus.ins_ready && n < 3000) begin
      @(negedge core_clk);
      n++;
    end
    if (!bus.ins_ready) begin
      check_value("send_ready", bus.ins_ready, 1'b1);
      bus.ins_valid = 1'b0;
    end else begin
      case (w[63:60])
        4'd0: begin model_c = int'(w[7:0]); busy = 1; end
        4'd1, 4'd3: busy = int'(w[43:32]) + 1;
        4'd2: busy = model_c + 1;
        default: busy = 1;
      endcase
      sb.push_back('{w: w, busy: busy});
      $display("send %016h busy=%0d", w, busy);
      @(posedge core_clk);
      #1;
      bus.ins_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((working || sb.size() != 0) && n < 5000) begin
      @(negedge core_clk);
      n++;
    end
    check_value("drain_working", working, 1'b0);
    check_value("drain_sb", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_ddr_pins();
    #2;
    check_value("c0_idle", {c0_act_n, c0_cs_n, c0_cke, c0_odt, c0_adr, c0_ba, c0_bg}, 24'hC00000);
    check_value("c1_idle", {c1_act_n, c1_cs_n, c1_cke, c1_odt, c1_adr, c1_ba, c1_bg}, 24'hC00000);
    check_value("ddr_rstn", {c0_reset_n, c1_reset_n}, {~sys_rst, ~sys_rst});
    check_value("ddr_clks", {c0_clk_p, c0_clk_n, c0_ck_t, c0_ck_c, c1_clk_p, c1_clk_n, c1_ck_t, c1_ck_c},
                {core_clk, ~core_clk, core_clk, ~core_clk, core_clk, ~core_clk, core_clk, ~core_clk});
  endtask

  // Monitor: count EXEC cycles per instruction and capture the head word on
  // the cycle it is popped.
  initial begin : monitor
    bit          in_run;
    int          run_cnt;
    logic [63:0] head;
    exp_t        e;
    in_run  = 1'b0;
    run_cnt = 0;
    head    = '0;
    forever begin
      @(negedge core_clk);
      if (!mon_en) begin
        in_run  = 1'b0;
        run_cnt = 0;
      end else if (dut.r_state == ST_EXEC) begin
        in_run = 1'b1;
        run_cnt++;
      end else begin
        if (in_run) begin
          check_value("sb_pending", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check_value("exec_word", head, e.w);
            check_value("exec_cycles", 64'(run_cnt), 64'(e.busy));
          end
          in_run  = 1'b0;
          run_cnt = 0;
        end
        if (!dut.w_fifo_empty) head = dut.w_fifo_rd_data;
      end
    end
  end

  initial begin : stim
    bus.ins_valid = 1'b1;
    bus.ins       = mk_conf(8'h33);

    // Reset, then calibration gating with valid held high.
    repeat (3) @(negedge core_clk);
    check_value("rst_ready", bus.ins_ready, 1'b0);
    check_value("rst_working", working, 1'b0);
    check_ddr_pins();
    sys_rst = 1'b0;
    repeat (3) @(negedge core_clk);
    check_value("nocal_ready", bus.ins_ready, 1'b0);
    check_value("nocal_working", working, 1'b0);
    check_value("nocal_empty", dut.w_fifo_empty, 1'b1);
    check_ddr_pins();
    bus.ins_valid = 1'b0;
    c0_cal = 1'b1;
    c1_cal = 1'b1;
    check_value("cal_ready_lag", bus.ins_ready, 1'b0);
    @(negedge core_clk);
    check_value("cal_ready", bus.ins_ready, 1'b1);
    mon_en = 1'b1;

    // CONF C=15 then CALC; working trails the first accept by one cycle.
    send(mk_conf(8'd15));
    check_value("working_lag", working, 1'b0);
    @(posedge core_clk);
    #1;
    check_value("working_rise", working, 1'b1);
    send({4'h2, 60'h0});
    wait_drain();

    // Two LOADs in order.
    send(mk_ls(4'h1, 12'd180, 32'h1000_0000));
    send(mk_ls(4'h1, 12'd198, 32'h2000_0000));
    wait_drain();

    // Five words behind a long LOAD fill the 4-deep queue.
    send(mk_ls(4'h1, 12'd300, 32'h3000_0000));
    send({4'h2, 60'h1});
    send({4'h9, 60'hABCDE});
    send(mk_conf(8'd3));
    send({4'h2, 60'h2});
    @(negedge core_clk);
    check_value("full_ready", bus.ins_ready, 1'b0);
    check_value("full_flag", dut.w_fifo_full, 1'b1);
    send(mk_ls(4'h3, 12'd5, 32'h4000_0000));
    wait_drain();

    // Data compare error: acceptance stops, queue still drains.
    send(mk_ls(4'h1, 12'd40, 32'h5000_0000));
    send({4'hF, 60'h7});
    send(mk_ls(4'h3, 12'd10, 32'h6000_0000));
    @(negedge core_clk);
    c1_err = 1'b1;
    @(negedge core_clk);
    c1_err = 1'b0;
    check_value("err_ready", bus.ins_ready, 1'b0);
    wait_drain();
    bus.ins_valid = 1'b1;
    bus.ins       = mk_conf(8'h44);
    repeat (5) @(negedge core_clk);
    check_value("err_ready_hold", bus.ins_ready, 1'b0);
    check_value("err_ignored", working, 1'b0);
    bus.ins_valid = 1'b0;
    sys_rst = 1'b1;
    model_c = 0;
    @(negedge core_clk);
    sys_rst = 1'b0;
    @(negedge core_clk);
    check_value("err_cleared", bus.ins_ready, 1'b1);

    // Reset in the middle of a LOAD with more work queued.
    send(mk_conf(8'd9));
    send(mk_ls(4'h1, 12'd500, 32'h7000_0000));
    send(mk_ls(4'h1, 12'd20, 32'h8000_0000));
    send({4'h2, 60'h3});
    repeat (30) @(negedge core_clk);
    mon_en  = 1'b0;
    sys_rst = 1'b1;
    @(negedge core_clk);
    check_value("midrst_working", working, 1'b0);
    check_value("midrst_empty", dut.w_fifo_empty, 1'b1);
    check_value("midrst_state", dut.r_state, ST_IDLE);
    check_value("midrst_ready", bus.ins_ready, 1'b0);
    sb.delete();
    model_c = 0;
    sys_rst = 1'b0;
    @(negedge core_clk);
    check_value("midrst_ready_back", bus.ins_ready, 1'b1);
    mon_en = 1'b1;
    // conf_reg was cleared, so CALC runs a single cycle.
    send({4'h2, 60'h4});
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
